// File: rtl/fhe_acc_pkg.sv
// rtl/fhe_acc_pkg.sv - shared types and constants for the RLWE accumulator key path
package fhe_acc_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int LINE_SIZE = 4;
  localparam int LINE_W    = BIT_WIDTH * LINE_SIZE;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic KEY_SEL_A = 1'b0;
  localparam logic KEY_SEL_B = 1'b1;

endpackage

// File: rtl/key_stage_reg.sv
// rtl/key_stage_reg.sv - one-entry skid stage holding a key line and its target FIFO select
module key_stage_reg #(
  parameter int LINE_W = fhe_acc_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [LINE_W-1:0] push_data,
  input  logic              push_sel,
  input  logic              pop,
  output logic              valid,
  output logic [LINE_W-1:0] data,
  output logic              sel
);

  logic              valid_q, valid_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              sel_q, sel_d;

  // A push in the same cycle as a pop replaces the entry, keeping the stage full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (push) begin
      valid_d = 1'b1;
      data_d  = push_data;
      sel_d   = push_sel;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign sel   = sel_q;

endmodule

// File: rtl/key_fifo_loader.sv
// rtl/key_fifo_loader.sv - demultiplexes the interleaved poly-a/poly-b key stream into two key FIFOs
module key_fifo_loader #(
  parameter int LINE_W = fhe_acc_pkg::LINE_W,
  parameter int LEN_W  = 12,
  parameter int KEY_W  = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [LEN_W-1:0]       length_lines,
  input  logic [KEY_W-1:0]       num_keys,
  input  logic                   in_valid,
  input  logic [LINE_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic [1:0]             key_full,
  output logic [1:0]             key_wr_en,
  output logic [1:0][LINE_W-1:0] key_din,
  output logic                   busy,
  output logic                   done
);

  import fhe_acc_pkg::*;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [LEN_W-1:0] line_cnt_q, line_cnt_d;
  logic [KEY_W-1:0] key_cnt_q, key_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [KEY_W-1:0] nkeys_q, nkeys_d;
  logic             done_q, done_d;

  logic              stage_valid;
  logic [LINE_W-1:0] stage_data;
  logic              stage_sel;
  logic              write_fire;
  logic              accept;
  logic [LEN_W-1:0]  len_last;
  logic [KEY_W-1:0]  nkeys_last;

  assign len_last   = len_q - LEN_W'(1);
  assign nkeys_last = nkeys_q - KEY_W'(1);

  // Only the target FIFO's full flag gates the write; the other flag is ignored.
  assign write_fire = stage_valid && !key_full[stage_sel];
  assign in_ready   = (state_q == LOAD) && (!stage_valid || write_fire);
  assign accept     = in_valid && in_ready;

  key_stage_reg #(.LINE_W(LINE_W)) u_stage (
    .clk       (clk),
    .rstn      (rstn),
    .push      (accept),
    .push_data (in_data),
    .push_sel  (sel_q),
    .pop       (write_fire),
    .valid     (stage_valid),
    .data      (stage_data),
    .sel       (stage_sel)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    line_cnt_d = line_cnt_q;
    key_cnt_d  = key_cnt_q;
    len_d      = len_q;
    nkeys_d    = nkeys_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A start coinciding with a done pulse is dropped so jobs never overlap.
        if (start && !done_q) begin
          len_d      = length_lines;
          nkeys_d    = num_keys;
          line_cnt_d = '0;
          key_cnt_d  = '0;
          sel_d      = KEY_SEL_A;
          if (num_keys == '0 || length_lines == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          sel_d = ~sel_q;
          if (sel_q == KEY_SEL_B) begin
            if (line_cnt_q == len_last) begin
              line_cnt_d = '0;
              key_cnt_d  = key_cnt_q + KEY_W'(1);
              if (key_cnt_q == nkeys_last) begin
                state_d = FLUSH;
              end
            end else begin
              line_cnt_d = line_cnt_q + LEN_W'(1);
            end
          end
        end
      end
      FLUSH: begin
        if (write_fire) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      sel_q      <= KEY_SEL_A;
      line_cnt_q <= '0;
      key_cnt_q  <= '0;
      len_q      <= '0;
      nkeys_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      line_cnt_q <= line_cnt_d;
      key_cnt_q  <= key_cnt_d;
      len_q      <= len_d;
      nkeys_q    <= nkeys_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    key_wr_en = 2'b00;
    if (write_fire) begin
      key_wr_en[stage_sel] = 1'b1;
    end
  end

  assign key_din = {stage_data, stage_data};
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_key_fifo_loader.sv
// tb/tb_key_fifo_loader.sv - scoreboard bench for key_fifo_loader
module tb_key_fifo_loader;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [11:0]      length_lines = '0;
  logic [15:0]      num_keys = '0;
  logic             in_valid = 1'b0;
  logic [63:0]      in_data = '0;
  logic             in_ready;
  logic [1:0]       key_full = 2'b00;
  logic [1:0]       key_wr_en;
  logic [1:0][63:0] key_din;
  logic             busy;
  logic             done;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  typedef struct {
    int nk;
    int len;
    int mode;   // 0 plain, 1 full[1] stall at b1, 2 full[0] during b1, 3 random gaps + re-start
    int w0;
    int w1;
  } job_t;
  job_t jobs[7];

  key_fifo_loader dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .length_lines (length_lines),
    .num_keys     (num_keys),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .key_full     (key_full),
    .key_wr_en    (key_wr_en),
    .key_din      (key_din),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int tag, input int beat);
    return {32'(tag), 32'(beat)};
  endfunction

  task automatic run_job(input int tag, input int nk, input int len, input int mode,
                         input int exp_w0, input int exp_w1);
    int total, beat, cyc, w0, w1, dones, first_acc, last_acc, last_wr, done_cyc;
    int stall_left, f0_left, f0_phase, after_done;
    logic accepted;
    logic [63:0] exp_d;
    total = 2 * nk * len;
    beat = 0; w0 = 0; w1 = 0; dones = 0;
    first_acc = -1; last_acc = -1; last_wr = -1; done_cyc = -1;
    stall_left = 0; f0_left = 0; f0_phase = 0; after_done = -1;
    @(negedge clk);
    start = 1'b1; num_keys = 16'(nk); length_lines = 12'(len);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 600 && after_done < 3) begin
      key_full = {stall_left > 0, f0_left > 0};
      in_valid = (beat < total) && (mode != 3 || $urandom_range(0, 2) != 0);
      in_data  = mk(tag, beat);
      start    = (mode == 3 && cyc == 6);
      if (start) begin
        num_keys = 16'd7; length_lines = 12'd9;
      end
      #1;
      if (cyc == 0) chk("busy_after_start", {63'd0, busy}, {63'd0, total != 0});
      if (stall_left > 0) begin
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_wr_en", {62'd0, key_wr_en}, 64'd0);
      end
      if (f0_phase == 1) chk("full0_b_write", {62'd0, key_wr_en}, 64'd2);
      if (f0_phase == 2) chk("full0_a_stall", {62'd0, key_wr_en}, 64'd0);
      if (key_wr_en != 2'b00) begin
        chk("wr_onehot", {63'd0, key_wr_en == 2'b11}, 64'd0);
        for (int f = 0; f < 2; f++) begin
          if (key_wr_en[f]) begin
            if ((f == 0 ? q0.size() : q1.size()) == 0) begin
              chk("write_unexpected", 64'd1, 64'd0);
            end else begin
              exp_d = (f == 0) ? q0.pop_front() : q1.pop_front();
              chk(f == 0 ? "din_fifo0" : "din_fifo1", key_din[f], exp_d);
              if (f == 0) w0++; else w1++;
            end
          end
        end
        last_wr = cyc;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        if (after_done < 0) after_done = 0;
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        if (beat % 2 == 0) q0.push_back(mk(tag, beat));
        else q1.push_back(mk(tag, beat));
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        beat++;
      end
      if (stall_left > 0) stall_left--;
      if (f0_left > 0) f0_left--;
      f0_phase = (f0_phase == 1) ? 2 : 0;
      if (accepted && beat == 4) begin
        if (mode == 1) stall_left = 5;
        if (mode == 2) begin
          f0_left = 2;
          f0_phase = 1;
        end
      end
      if (after_done >= 0) after_done++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; key_full = 2'b00;
    if (after_done < 0) chk("timeout_no_done", 64'd1, 64'd0);
    chk("writes_fifo0", 64'(w0), 64'(exp_w0));
    chk("writes_fifo1", 64'(w1), 64'(exp_w1));
    chk("done_pulses", 64'(dones), 64'd1);
    chk("beats_accepted", 64'(beat), 64'(total));
    chk("sb_left0", 64'(q0.size()), 64'd0);
    chk("sb_left1", 64'(q1.size()), 64'd0);
    chk("idle_after_job", {63'd0, busy}, 64'd0);
    if (total == 0) chk("zero_job_done_lat", 64'(done_cyc), 64'd0);
    if (mode == 0 && total == 8) begin
      chk("burst_8_cycles", 64'(last_acc - first_acc), 64'd7);
      chk("done_after_last_wr", 64'(done_cyc - last_wr), 64'd1);
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    jobs[0] = '{1, 4, 0, 4, 4};
    jobs[1] = '{1, 4, 1, 4, 4};
    jobs[2] = '{1, 4, 2, 4, 4};
    jobs[3] = '{0, 4, 0, 0, 0};
    jobs[4] = '{3, 0, 0, 0, 0};
    jobs[5] = '{3, 2, 3, 6, 6};
    jobs[6] = '{2, 3, 0, 6, 6};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_wr_en", {62'd0, key_wr_en}, 64'd0);
    chk("rst_din0", key_din[0], 64'd0);
    chk("rst_din1", key_din[1], 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rstn = 1'b1;

    for (int j = 0; j < 7; j++) begin
      run_job(j + 1, jobs[j].nk, jobs[j].len, jobs[j].mode, jobs[j].w0, jobs[j].w1);
    end

    // Reset pulse in the middle of a load.
    @(negedge clk);
    start = 1'b1; num_keys = 16'd2; length_lines = 12'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = mk(8, i);
      @(negedge clk);
    end
    rstn = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst_wr_en", {62'd0, key_wr_en}, 64'd0);
    chk("midrst_din0", key_din[0], 64'd0);
    chk("midrst_din1", key_din[1], 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    run_job(9, 1, 1, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
